// File: rtl/force_run_accumulator.sv
// rtl/force_run_accumulator.sv - merges back-to-back force entries per particle id; ACC_SATURATE_EN selects clamping adds
module force_run_accumulator #(
  parameter int ID_W    = 16,
  parameter int FORCE_W = 16,
  parameter int CNT_W   = 4,
  parameter int TIMEOUT = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      buf_empty,
  input  logic [ID_W+3*FORCE_W-1:0] buf_data,
  output logic                      buf_consume,
  input  logic                      flush,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [ID_W+3*FORCE_W-1:0] out_data,
  output logic [CNT_W-1:0]          out_count
);
  localparam int DW = ID_W + 3 * FORCE_W;
  localparam int TW = $clog2(TIMEOUT) + 1;
  localparam logic [TW-1:0]    T_LAST   = TW'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic {EMPTY, ACCUM} state_t;

  state_t               state_q, state_d;
  logic [ID_W-1:0]      acc_id_q, acc_id_d;
  logic [FORCE_W-1:0]   acc_fx_q, acc_fx_d, acc_fy_q, acc_fy_d, acc_fz_q, acc_fz_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [TW-1:0]        timer_q, timer_d;
  logic                 rd_valid_q, rd_valid_d;
  logic                 out_valid_q, out_valid_d;
  logic [DW-1:0]        out_data_q, out_data_d;
  logic [CNT_W-1:0]     out_count_q, out_count_d;

  logic [ID_W-1:0]      in_id;
  logic [FORCE_W-1:0]   in_fx, in_fy, in_fz;
  logic                 slot_free, merge, take;

  function automatic logic [FORCE_W-1:0] add_f(input logic [FORCE_W-1:0] a, input logic [FORCE_W-1:0] b);
`ifdef ACC_SATURATE_EN
    logic [FORCE_W:0] s;
    s = {a[FORCE_W-1], a} + {b[FORCE_W-1], b};
    if (s[FORCE_W] != s[FORCE_W-1])
      return s[FORCE_W] ? {1'b1, {(FORCE_W-1){1'b0}}} : {1'b0, {(FORCE_W-1){1'b1}}};
    return s[FORCE_W-1:0];
`else
    return a + b;
`endif
  endfunction

  assign in_id = buf_data[DW-1 -: ID_W];
  assign in_fx = buf_data[3*FORCE_W-1 -: FORCE_W];
  assign in_fy = buf_data[2*FORCE_W-1 -: FORCE_W];
  assign in_fz = buf_data[FORCE_W-1:0];

  assign slot_free   = ~out_valid_q | out_ready;
  assign merge       = (state_q == ACCUM) & (in_id == acc_id_q) & (cnt_q != CNT_MAX);
  assign take        = rd_valid_q & ((state_q == EMPTY) | merge | slot_free);
  assign buf_consume = ~buf_empty & (~rd_valid_q | take);

  always_comb begin
    state_d     = state_q;
    acc_id_d    = acc_id_q;
    acc_fx_d    = acc_fx_q;
    acc_fy_d    = acc_fy_q;
    acc_fz_d    = acc_fz_q;
    cnt_d       = cnt_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_count_d = out_count_q;
    rd_valid_d  = buf_consume ? 1'b1 : (take ? 1'b0 : rd_valid_q);

    // Clear the handshake first; an emit below may re-arm the slot in the same cycle.
    if (out_valid_q && out_ready) out_valid_d = 1'b0;

    if (take && (state_q == ACCUM) && !merge) begin
      out_valid_d = 1'b1;
      out_data_d  = {acc_id_q, acc_fx_q, acc_fy_q, acc_fz_q};
      out_count_d = cnt_q;
    end

    case (state_q)
      EMPTY: begin
        if (take) begin
          state_d  = ACCUM;
          acc_id_d = in_id;
          acc_fx_d = in_fx;
          acc_fy_d = in_fy;
          acc_fz_d = in_fz;
          cnt_d    = CNT_ONE;
        end
      end
      ACCUM: begin
        if (take && merge) begin
          acc_fx_d = add_f(acc_fx_q, in_fx);
          acc_fy_d = add_f(acc_fy_q, in_fy);
          acc_fz_d = add_f(acc_fz_q, in_fz);
          cnt_d    = cnt_q + CNT_ONE;
        end else if (take) begin
          acc_id_d = in_id;
          acc_fx_d = in_fx;
          acc_fy_d = in_fy;
          acc_fz_d = in_fz;
          cnt_d    = CNT_ONE;
        end else if (!rd_valid_q && ((timer_q == T_LAST) || (flush && buf_empty)) && slot_free) begin
          state_d     = EMPTY;
          out_valid_d = 1'b1;
          out_data_d  = {acc_id_q, acc_fx_q, acc_fy_q, acc_fz_q};
          out_count_d = cnt_q;
        end
      end
      default: state_d = EMPTY;
    endcase

    if (take || (state_q == EMPTY)) timer_d = '0;
    else if (timer_q != T_LAST)     timer_d = timer_q + TW'(1);
    else                            timer_d = timer_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= EMPTY;
      acc_id_q    <= '0;
      acc_fx_q    <= '0;
      acc_fy_q    <= '0;
      acc_fz_q    <= '0;
      cnt_q       <= '0;
      timer_q     <= '0;
      rd_valid_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_count_q <= '0;
    end else begin
      state_q     <= state_d;
      acc_id_q    <= acc_id_d;
      acc_fx_q    <= acc_fx_d;
      acc_fy_q    <= acc_fy_d;
      acc_fz_q    <= acc_fz_d;
      cnt_q       <= cnt_d;
      timer_q     <= timer_d;
      rd_valid_q  <= rd_valid_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_count_q <= out_count_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_count = out_count_q;
endmodule

// File: tb/tb_force_run_accumulator.sv
// tb/tb_force_run_accumulator.sv - scoreboard bench for force_run_accumulator
module tb_force_run_accumulator;
  localparam int TO = 32;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        buf_empty = 1'b1;
  logic [63:0] buf_data = '0;
  logic        flush = 1'b0;
  logic        out_ready = 1'b1;
  logic        buf_consume, out_valid;
  logic [63:0] out_data;
  logic [3:0]  out_count;

  force_run_accumulator #(.ID_W(16), .FORCE_W(16), .CNT_W(4), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .buf_empty(buf_empty), .buf_data(buf_data), .buf_consume(buf_consume),
    .flush(flush), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_count(out_count)
  );

  always #5 clk = ~clk;

  typedef struct { logic [63:0] data; logic [3:0] cnt; } rec_t;
  rec_t        exp_q[$];
  logic [63:0] fifo[$];
  int          checks = 0, failures = 0, cyc = 0;
  logic        pop_s = 1'b0;
  logic [15:0] last_fx = '0;

  bit          m_open = 0;
  logic [15:0] m_id, m_fx, m_fy, m_fz;
  int          m_cnt;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] m_add(input logic [15:0] a, input logic [15:0] b);
    int s;
    s = int'($signed(a)) + int'($signed(b));
`ifdef ACC_SATURATE_EN
    if (s > 32767)  s = 32767;
    if (s < -32768) s = -32768;
`endif
    return 16'(s);
  endfunction

  task automatic model_close();
    rec_t r;
    if (m_open) begin
      r.data = {m_id, m_fx, m_fy, m_fz};
      r.cnt  = 4'(m_cnt);
      exp_q.push_back(r);
      m_open = 0;
    end
  endtask

  task automatic push_entry(input logic [15:0] id, input logic [15:0] fx, input logic [15:0] fy, input logic [15:0] fz);
    if (m_open && (id != m_id || m_cnt == 15)) model_close();
    if (!m_open) begin
      m_open = 1; m_id = id; m_fx = fx; m_fy = fy; m_fz = fz; m_cnt = 1;
    end else begin
      m_fx = m_add(m_fx, fx); m_fy = m_add(m_fy, fy); m_fz = m_add(m_fz, fz); m_cnt++;
    end
    fifo.push_back({id, fx, fy, fz});
    buf_empty = 1'b0;
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_drain(input string tag);
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !out_valid && fifo.size() == 0) break;
    end
    chk(tag, exp_q.size(), 0);
    tick(1);
  endtask

  // Buffer model: registered output updates one cycle after an accepted pop.
  always @(negedge clk) pop_s = buf_consume && !buf_empty;
  always @(posedge clk) begin
    cyc++;
    #1;
    if (pop_s && fifo.size() > 0) buf_data = fifo.pop_front();
    buf_empty = (fifo.size() == 0);
  end

  always @(negedge clk) begin
    rec_t e;
    if (!rst && out_valid && out_ready) begin
      chk("rec_pending", exp_q.size() > 0, 1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("rec_data", out_data, e.data);
        chk("rec_count", out_count, e.cnt);
      end
      last_fx = out_data[47:32];
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    int pc, oc;
    repeat (3) @(negedge clk);
    chk("rst_consume", buf_consume, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_data", out_data, 0);
    chk("rst_count", out_count, 0);
    @(posedge clk); #1 rst = 1'b0;
    tick(2);

    for (int i = 1; i <= 3; i++) push_entry(16'd5, 16'(i), 16'd0, 16'd0);
    model_close();
    flush = 1'b1;
    wait_drain("t1_drain");
    flush = 1'b0;

    push_entry(16'd5, 16'd10, 16'hFFFF, 16'd3);
    push_entry(16'd7, 16'd20, 16'hFFFE, 16'd4);
    push_entry(16'd7, 16'd21, 16'hFFF0, 16'd5);
    push_entry(16'd9, 16'd30, 16'd1, 16'hFF00);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (buf_empty) break;
      chk("t2_consume", buf_consume, 1);
    end
    model_close();
    tick(1);
    flush = 1'b1;
    wait_drain("t2_drain");
    flush = 1'b0;

    for (int i = 0; i < 16; i++) push_entry(16'd3, 16'd1, 16'd0, 16'd0);
    model_close();
    flush = 1'b1;
    wait_drain("t3_drain");
    flush = 1'b0;

    push_entry(16'd4, 16'd2, 16'd3, 16'd4);
    model_close();
    pc = -1;
    oc = -1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (buf_consume && !buf_empty) begin pc = cyc; break; end
    end
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (out_valid) begin oc = cyc; break; end
    end
    chk("t4_latency", oc - pc, TO + 2);
    wait_drain("t4_drain");

    out_ready = 1'b0;
    for (int i = 1; i <= 4; i++) push_entry(16'(i), 16'(i * 10), 16'd0, 16'd1);
    model_close();
    tick(10);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t5_hold_valid", out_valid, 1);
      chk("t5_hold_id", out_data[63:48], 16'd1);
      chk("t5_stall", buf_consume, 0);
    end
    tick(1);
    out_ready = 1'b1;
    flush = 1'b1;
    wait_drain("t5_drain");
    flush = 1'b0;

    push_entry(16'd6, 16'h7000, 16'h9000, 16'h1234);
    push_entry(16'd6, 16'h7000, 16'h9000, 16'h1234);
    model_close();
    flush = 1'b1;
    wait_drain("t6_drain");
    flush = 1'b0;
`ifdef ACC_SATURATE_EN
    chk("t6_fx_sat", last_fx, 16'h7FFF);
`else
    chk("t6_fx_wrap", last_fx, 16'hE000);
`endif

    push_entry(16'd8, 16'd1, 16'd1, 16'd1);
    push_entry(16'd8, 16'd1, 16'd1, 16'd1);
    m_open = 0;
    tick(6);
    rst = 1'b1;
    fifo.delete();
    buf_empty = 1'b1;
    tick(1);
    @(negedge clk);
    chk("rst_mid_valid", out_valid, 0);
    chk("rst_mid_count", out_count, 0);
    @(posedge clk); #1 rst = 1'b0;
    flush = 1'b1;
    tick(TO + 10);
    @(negedge clk);
    chk("rst_no_output", out_valid, 0);
    flush = 1'b0;

    chk("scoreboard_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
